// File: rtl/sdram_image_loader.sv
// Parses a framed little-endian byte stream into 16-bit SDRAM backdoor writes
// and holds the SoC in reset until the zero-length end frame arrives.
module sdram_image_loader #(
    parameter int COL_WIDTH  = 9,
    parameter int BANK_WIDTH = 2,
    parameter int ROW_WIDTH  = 13
) (
    input  logic        io_axiClk,
    input  logic        io_reset,
    input  logic        io_input_valid,
    output logic        io_input_ready,
    input  logic [7:0]  io_input_payload,
    output logic        loader_valid,
    output logic [15:0] loader_data,
    output logic [BANK_WIDTH-1:0] loader_bank,
    output logic [31:0] loader_address,
    output logic        io_socReset,
    output logic        io_done,
    output logic [31:0] io_loadedWords
);

    localparam int WA_W = COL_WIDTH + BANK_WIDTH + ROW_WIDTH;
    localparam int RC_W = ROW_WIDTH + COL_WIDTH;

    typedef enum logic [1:0] {HDR_ADDR, HDR_LEN, DATA, DONE} state_t;

    state_t          state;
    logic [1:0]      hdr_cnt;
    logic [23:0]     hdr_sr;
    logic [WA_W-1:0] waddr;
    logic [31:0]     remaining;
    logic            odd_phase;
    logic [7:0]      low_byte;

    logic            accept;
    logic [31:0]     hdr_word;
    logic            emit;
    logic [15:0]     emit_data;
    logic [RC_W-1:0] row_col;

    assign io_input_ready = (state != DONE) && !io_reset;
    assign accept         = io_input_valid && io_input_ready;
    // Header bytes arrive LSB first; the shift register holds the first three.
    assign hdr_word       = {io_input_payload, hdr_sr};
    assign row_col        = {waddr[WA_W-1:COL_WIDTH+BANK_WIDTH], waddr[COL_WIDTH-1:0]};

    always_comb begin
        emit      = 1'b0;
        emit_data = {io_input_payload, low_byte};
        if (state == DATA && accept) begin
            if (odd_phase) begin
                emit = 1'b1;
            end else if (remaining == 32'd1) begin
                emit      = 1'b1;
                emit_data = {8'h00, io_input_payload};
            end
        end
    end

    always_ff @(posedge io_axiClk) begin
        if (io_reset) begin
            state          <= HDR_ADDR;
            hdr_cnt        <= '0;
            hdr_sr         <= '0;
            waddr          <= '0;
            remaining      <= '0;
            odd_phase      <= 1'b0;
            low_byte       <= '0;
            loader_valid   <= 1'b0;
            loader_data    <= '0;
            loader_bank    <= '0;
            loader_address <= '0;
            io_socReset    <= 1'b1;
            io_done        <= 1'b0;
            io_loadedWords <= '0;
        end else begin
            loader_valid <= 1'b0;
            if (emit) begin
                loader_valid   <= 1'b1;
                loader_data    <= emit_data;
                loader_bank    <= waddr[COL_WIDTH+BANK_WIDTH-1:COL_WIDTH];
                loader_address <= {{(32-RC_W){1'b0}}, row_col};
                waddr          <= waddr + WA_W'(1);
                io_loadedWords <= io_loadedWords + 32'd1;
            end
            if (accept) begin
                case (state)
                    HDR_ADDR, HDR_LEN: begin
                        hdr_sr  <= hdr_word[31:8];
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd3) begin
                            if (state == HDR_ADDR) begin
                                waddr <= hdr_word[WA_W:1];
                                state <= HDR_LEN;
                            end else if (hdr_word == 32'd0) begin
                                state       <= DONE;
                                io_done     <= 1'b1;
                                io_socReset <= 1'b0;
                            end else begin
                                remaining <= hdr_word;
                                odd_phase <= 1'b0;
                                state     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        remaining <= remaining - 32'd1;
                        odd_phase <= !odd_phase;
                        if (!odd_phase) begin
                            low_byte <= io_input_payload;
                        end
                        if (remaining == 32'd1) begin
                            state   <= HDR_ADDR;
                            hdr_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
